rf_write_arbiter: RTL and testbench

- Shares the register file's single write port (3-bit address, write enable, data) among N_REQ requesters, e.g. the bus interface, the multiplier writeback and the factorial sequencer.
- Grants one write per cycle using round-robin priority.
- Supports an optional lock so one requester can issue back-to-back writes, and drops writes to out-of-range addresses.
- Drives the register-file write decoder directly from registered outputs.

---
 rtl/rf_pkg.sv | 28 ++
 rtl/rr_pick.sv | 33 +++
 rtl/rf_write_arbiter.sv | 162 ++++++++++++++++
 tb/tb_rf_write_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants for the register-file write path: address space, arbiter
// state encoding and the fixed requester slots.
package rf_pkg;

    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 7;

    // Widest requester set any arbiter in this path supports; owner/ptr are sized for it.
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    localparam logic [IDX_W-1:0] REQ_BUS = 3'd0;
    localparam logic [IDX_W-1:0] REQ_MUL = 3'd1;
    localparam logic [IDX_W-1:0] REQ_SEQ = 3'd2;

    // Round-robin successor of idx within n active slots.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx, input int n);
        if (int'(idx) >= n - 1)
            return '0;
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: grants the first set request found when
// scanning upward from ptr, wrapping at N.
module rr_pick #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W:0] pos;
    logic           found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(k);
            if (pos >= (IDX_W+1)'(N))
                pos = pos - (IDX_W+1)'(N);
            if (!found && req[pos[IDX_W-1:0]]) begin
                found                  = 1'b1;
                grant[pos[IDX_W-1:0]]  = 1'b1;
                idx                    = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the register file's single write port, with
// per-requester lock, lock timeout and out-of-range address filtering.
module rf_write_arbiter #(
    parameter int N_REQ    = 3,
    parameter int ADDR_W   = rf_pkg::ADDR_W,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = rf_pkg::NUM_REGS,
    parameter int LOCK_TO  = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_lock,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    we,
    output logic [ADDR_W-1:0]       Addr,
    output logic [DATA_W-1:0]       wData,
    output logic                    err_addr,
    output logic                    lock_timeout,
    output logic [2:0]              owner
);

    import rf_pkg::*;

    // Requester-side vectors widened to MAX_REQ so ptr/owner index them without width games.
    logic [MAX_REQ-1:0] valid_full;
    logic [MAX_REQ-1:0] lock_full;
    logic [ADDR_W-1:0]  addr_arr [MAX_REQ];
    logic [DATA_W-1:0]  data_arr [MAX_REQ];

    generate
        for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_unpack
            if (gi < N_REQ) begin : g_used
                assign valid_full[gi] = req_valid[gi];
                assign lock_full[gi]  = req_lock[gi];
                assign addr_arr[gi]   = req_addr[gi*ADDR_W +: ADDR_W];
                assign data_arr[gi]   = req_data[gi*DATA_W +: DATA_W];
            end else begin : g_unused
                assign valid_full[gi] = 1'b0;
                assign lock_full[gi]  = 1'b0;
                assign addr_arr[gi]   = '0;
                assign data_arr[gi]   = '0;
            end
        end
    endgenerate

    arb_state_t         state_reg;
    logic [IDX_W-1:0]   ptr_reg;
    logic [IDX_W-1:0]   owner_reg;
    logic [7:0]         cnt_reg;
    logic               we_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [DATA_W-1:0]  data_reg;
    logic               err_reg;
    logic               timeout_reg;

    logic [MAX_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;

    // Unused upper slots are never requested, so scanning mod MAX_REQ equals scanning mod N_REQ.
    rr_pick #(
        .N     (MAX_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (valid_full),
        .ptr   (ptr_reg),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    logic [MAX_REQ-1:0] ready_full;
    logic               xfer;
    logic [IDX_W-1:0]   xfer_idx;
    logic [ADDR_W-1:0]  addr_sel;
    logic [DATA_W-1:0]  data_sel;
    logic               lock_sel;
    logic               addr_ok;
    logic               timeout_hit;

    always_comb begin
        ready_full = '0;
        if (reset_n) begin
            if (state_reg == ST_IDLE)
                ready_full = pick_grant;
            else
                ready_full[owner_reg] = valid_full[owner_reg];
        end
    end

    assign xfer        = |ready_full;
    assign xfer_idx    = (state_reg == ST_IDLE) ? pick_idx : owner_reg;
    assign addr_sel    = addr_arr[xfer_idx];
    assign data_sel    = data_arr[xfer_idx];
    assign lock_sel    = lock_full[xfer_idx];
    assign addr_ok     = int'(addr_sel) < NUM_REGS;
    assign timeout_hit = (cnt_reg == 8'(LOCK_TO - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            ptr_reg     <= '0;
            owner_reg   <= '0;
            cnt_reg     <= '0;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            data_reg    <= '0;
            err_reg     <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            we_reg      <= 1'b0;
            err_reg     <= 1'b0;
            timeout_reg <= 1'b0;

            if (xfer) begin
                if (addr_ok) begin
                    we_reg   <= 1'b1;
                    addr_reg <= addr_sel;
                    data_reg <= data_sel;
                end else begin
                    err_reg  <= 1'b1;
                end
                ptr_reg   <= rr_next(xfer_idx, N_REQ);
                owner_reg <= xfer_idx;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (xfer && lock_sel) begin
                        state_reg <= ST_LOCKED;
                        cnt_reg   <= '0;
                    end
                end
                ST_LOCKED: begin
                    // A transfer from the owner always beats an expiring timeout.
                    if (xfer) begin
                        cnt_reg <= '0;
                        if (!lock_sel)
                            state_reg <= ST_IDLE;
                    end else if (timeout_hit) begin
                        state_reg   <= ST_IDLE;
                        timeout_reg <= 1'b1;
                        cnt_reg     <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign req_ready    = ready_full[N_REQ-1:0];
    assign we           = we_reg;
    assign Addr         = addr_reg;
    assign wData        = data_reg;
    assign err_addr     = err_reg;
    assign lock_timeout = timeout_reg;
    assign owner        = owner_reg;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized + directed bench for rf_write_arbiter against a cycle-level
// behavioural model of the arbitration, lock and output rules.
module tb_rf_write_arbiter;

    localparam int N  = 3;
    localparam int AW = 3;
    localparam int DW = 32;
    localparam int NR = 7;
    localparam int LT = 8;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_lock;
    logic [N*AW-1:0]     req_addr;
    logic [N*DW-1:0]     req_data;
    logic [N-1:0]        req_ready;
    logic                we;
    logic [AW-1:0]       Addr;
    logic [DW-1:0]       wData;
    logic                err_addr;
    logic                lock_timeout;
    logic [2:0]          owner;

    rf_write_arbiter #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .LOCK_TO(LT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_lock(req_lock),
        .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .we(we), .Addr(Addr), .wData(wData),
        .err_addr(err_addr), .lock_timeout(lock_timeout), .owner(owner)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Pending request held by each requester until it is transferred.
    bit          pv [N];
    bit          pl [N];
    int          pa [N];
    logic [31:0] pd [N];
    int          sleep_cnt [N];
    int          last_x;

    // Reference model state.
    int          m_ptr;
    int          m_lock;
    int          m_idle;
    bit          exp_we, exp_err, exp_to;
    int          exp_addr, exp_owner;
    logic [31:0] exp_data;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = pv[i];
            req_lock[i]           = pl[i];
            req_addr[i*AW +: AW]  = AW'(pa[i]);
            req_data[i*DW +: DW]  = pd[i];
        end
    endtask

    task automatic set_req(input int i, input int a, input logic [31:0] d, input bit l);
        pv[i] = 1'b1; pa[i] = a; pd[i] = d; pl[i] = l;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            pv[i] = 1'b0; pl[i] = 1'b0; pa[i] = 0; pd[i] = '0; sleep_cnt[i] = 0;
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_lock = -1; m_idle = 0;
        exp_we = 0; exp_err = 0; exp_to = 0;
        exp_addr = 0; exp_owner = 0; exp_data = '0;
    endtask

    // One arbitration cycle: starts just after a rising edge, ends just after the next.
    task automatic step();
        logic [N-1:0] er;
        drive();
        #1;
        er = '0;
        if (m_lock >= 0) begin
            er[m_lock] = pv[m_lock];
        end else begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (pv[j]) begin
                    er[j] = 1'b1;
                    break;
                end
            end
        end
        chk("req_ready", 64'(req_ready), 64'(er));

        last_x = -1;
        for (int i = 0; i < N; i++)
            if (er[i]) last_x = i;

        exp_we = 0; exp_err = 0; exp_to = 0;
        if (last_x >= 0) begin
            if (pa[last_x] < NR) begin
                exp_we = 1; exp_addr = pa[last_x]; exp_data = pd[last_x];
            end else begin
                exp_err = 1;
            end
            m_ptr     = (last_x + 1) % N;
            exp_owner = last_x;
            m_idle    = 0;
            m_lock    = pl[last_x] ? last_x : -1;
            $display("xfer req=%0d addr=%0d data=%08h lock=%0b", last_x, pa[last_x], pd[last_x], pl[last_x]);
        end else if (m_lock >= 0) begin
            m_idle++;
            if (m_idle == LT) begin
                exp_to = 1; m_lock = -1; m_idle = 0;
            end
        end

        @(posedge clk);
        #1;
        chk("we", 64'(we), 64'(exp_we));
        chk("err_addr", 64'(err_addr), 64'(exp_err));
        chk("lock_timeout", 64'(lock_timeout), 64'(exp_to));
        chk("owner", 64'(owner), 64'(exp_owner));
        chk("Addr", 64'(Addr), 64'(exp_addr));
        chk("wData", 64'(wData), 64'(exp_data));

        if (last_x >= 0) begin
            pv[last_x] = 1'b0;
            pl[last_x] = 1'b0;
        end
    endtask

    // Asserts reset asynchronously, checks the cleared state, then realigns to step timing.
    task automatic do_reset();
        drive();
        reset_n = 1'b0;
        #1;
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_owner", 64'(owner), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_addr", 64'(Addr), 64'd0);
        chk("rst_wdata", 64'(wData), 64'd0);
        chk("rst_err", 64'(err_addr), 64'd0);
        chk("rst_to", 64'(lock_timeout), 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        clear_reqs();
        drive();
        @(posedge clk);
        #1;
        chk("post_rst_we", 64'(we), 64'd0);
    endtask

    initial begin
        reset_n = 1'b1;
        clear_reqs();
        model_reset();
        drive();
        #3;
        do_reset();

        // All three requesters at once: strict rotation 0,1,2 with one write per cycle.
        set_req(0, 1, 32'hAAAA_0001, 0);
        set_req(1, 2, 32'hBBBB_0002, 0);
        set_req(2, 3, 32'hCCCC_0003, 0);
        repeat (4) step();

        // Move ptr to 1, then req0 and req2 compete: req2 wins first.
        set_req(0, 4, 32'h0000_0044, 0);
        step();
        set_req(0, 5, 32'h0000_0055, 0);
        set_req(2, 6, 32'h0000_0066, 0);
        repeat (3) step();

        // req1 holds the lock over three transfers while req0 waits.
        set_req(0, 0, 32'h1111_0000, 0);
        set_req(1, 1, 32'h2222_0001, 1);
        step();
        set_req(1, 2, 32'h2222_0002, 1);
        step();
        set_req(1, 3, 32'h2222_0003, 0);
        step();
        step();

        // req2 locks then goes quiet: timeout after LT idle cycles, then req0 is served.
        set_req(2, 4, 32'h3333_0004, 1);
        set_req(0, 5, 32'h1111_0005, 0);
        step();
        repeat (LT) step();
        step();

        // Out-of-range address completes but produces no write.
        set_req(0, 7, 32'hDEAD_BEEF, 0);
        step();
        step();

        // Reset while locked with a write sitting in the output stage.
        set_req(1, 2, 32'h5555_0002, 1);
        step();
        set_req(1, 3, 32'h5555_0003, 1);
        drive();
        #2;
        do_reset();
        set_req(0, 1, 32'h6666_0001, 0);
        set_req(1, 2, 32'h6666_0002, 0);
        set_req(2, 3, 32'h6666_0003, 0);
        repeat (4) step();

        // Randomized traffic with sleeps long enough to expire locks now and then.
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pv[i]) begin
                    if (sleep_cnt[i] > 0) sleep_cnt[i]--;
                    else if ($urandom_range(0, 1) == 1)
                        set_req(i, int'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2) == 0);
                end
            end
            step();
            if (last_x >= 0) sleep_cnt[last_x] = int'($urandom_range(0, 12));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
